// File: rtl/peak_bin_detect.sv
// Scans FFT RAM 1 over bins BIN_LO..BIN_HI and reports the bin with the highest power.
// A valid tag and bin index travel with each read, through read, power and compare.
//
// state | meaning
// IDLE  | after reset, waiting for start
// SCAN  | issuing read addresses BIN_LO..BIN_HI, one per cycle
// DRAIN | address sweep finished, in-flight bins still retiring
// DONE  | result valid, rdaddr1 parked on maxbin
module peak_bin_detect #(
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 511
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [27:0] minpwr,
  input  logic [27:0] ram1q,
  output logic [9:0]  rdaddr1,
  output logic [9:0]  maxbin,
  output logic [27:0] maxpwr,
  output logic        found,
  output logic        detectdone,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t      state;
  logic        v1, v2;
  logic [9:0]  bin1, bin2;
  logic [27:0] pwr2;
  logic [27:0] runmax;
  logic [9:0]  runbin;

  logic signed [13:0] re, im;
  logic signed [27:0] re_ext, im_ext, re_sq, im_sq;
  logic        [27:0] pwr_c;

  // Each square is at most 2^26, so the 28-bit unsigned sum never wraps.
  assign re     = ram1q[27:14];
  assign im     = ram1q[13:0];
  assign re_ext = 28'(re);
  assign im_ext = 28'(im);
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;
  assign pwr_c  = $unsigned(re_sq) + $unsigned(im_sq);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rdaddr1    <= '0;
      maxbin     <= '0;
      maxpwr     <= '0;
      found      <= 1'b0;
      detectdone <= 1'b0;
      busy       <= 1'b0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      bin1       <= '0;
      bin2       <= '0;
      pwr2       <= '0;
      runmax     <= '0;
      runbin     <= '0;
    end else begin
      v1   <= (state == SCAN);
      bin1 <= rdaddr1;
      v2   <= v1;
      bin2 <= bin1;
      pwr2 <= pwr_c;

      // Strict greater-than keeps the lower bin on ties.
      if (v2 && (pwr2 > runmax)) begin
        runmax <= pwr2;
        runbin <= bin2;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SCAN;
            rdaddr1    <= 10'(BIN_LO);
            runmax     <= '0;
            runbin     <= 10'(BIN_LO);
            found      <= 1'b0;
            detectdone <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SCAN: begin
          if (rdaddr1 == 10'(BIN_HI)) state <= DRAIN;
          else                        rdaddr1 <= rdaddr1 + 10'd1;
        end
        DRAIN: begin
          if (!v1 && !v2) begin
            state      <= DONE;
            maxbin     <= runbin;
            maxpwr     <= runmax;
            found      <= (runmax >= minpwr);
            detectdone <= 1'b1;
            busy       <= 1'b0;
            rdaddr1    <= runbin;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_bin_detect.sv
// Directed bench for peak_bin_detect: full 1..511 scan instance and a single-bin instance.
module tb_peak_bin_detect;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start2;
  logic [27:0] minpwr, minpwr2;
  logic [27:0] ram1q, ram1q2;
  logic [9:0]  rdaddr1, maxbin, rdaddr12, maxbin2;
  logic [27:0] maxpwr, maxpwr2;
  logic        found, detectdone, busy, found2, detectdone2, busy2;

  logic [27:0] mem1 [1024];
  logic [27:0] mem2 [1024];

  int ncmp  = 0;
  int nfail = 0;
  int edges;

  always #5 clk = ~clk;

  always @(posedge clk) ram1q  <= mem1[rdaddr1];
  always @(posedge clk) ram1q2 <= mem2[rdaddr12];

  peak_bin_detect dut (
    .clk(clk), .reset(reset), .start(start), .minpwr(minpwr), .ram1q(ram1q),
    .rdaddr1(rdaddr1), .maxbin(maxbin), .maxpwr(maxpwr), .found(found),
    .detectdone(detectdone), .busy(busy)
  );

  peak_bin_detect #(.BIN_LO(5), .BIN_HI(5)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .minpwr(minpwr2), .ram1q(ram1q2),
    .rdaddr1(rdaddr12), .maxbin(maxbin2), .maxpwr(maxpwr2), .found(found2),
    .detectdone(detectdone2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
  endtask

  // Pulses start, counts edges to detectdone (bounded); optional re-pulse mid-scan.
  task automatic run_scan(input int repulse, output int n);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("start_dd_low", 32'(detectdone), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_addr", 32'(rdaddr1), 32'd1);
    n = 0;
    while (n < 700) begin
      @(posedge clk); #1; n++;
      if (detectdone) break;
      start = (n == repulse);
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int e, input int bin, input int pwr, input int fnd);
    check({tag, "_edge"},   32'(edges), 32'(e));
    check({tag, "_maxbin"}, 32'(maxbin), 32'(bin));
    check({tag, "_maxpwr"}, 32'(maxpwr), 32'(pwr));
    check({tag, "_found"},  32'(found), 32'(fnd));
    check({tag, "_addr"},   32'(rdaddr1), 32'(bin));
    check({tag, "_busy"},   32'(busy), 32'd0);
  endtask

  initial begin
    start = 0; start2 = 0; minpwr = 28'd1000; minpwr2 = 28'd1;
    clear_mem();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 32'(rdaddr1), 32'd0);
    check("rst_maxbin", 32'(maxbin), 32'd0);
    check("rst_maxpwr", 32'(maxpwr), 32'd0);
    check("rst_flags", {29'd0, found, detectdone, busy}, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_addr", 32'(rdaddr1), 32'd0);

    // single bin 37 = {100, -50}
    mem1[37] = {14'sd100, -14'sd50};
    run_scan(0, edges);
    check_result("bin37", 514, 37, 12500, 1);

    // equal full-scale peaks at 20 and 300
    clear_mem();
    mem1[20]  = {14'h2000, 14'h2000};
    mem1[300] = {14'h2000, 14'h2000};
    run_scan(0, edges);
    check_result("tie", 514, 20, 134217728, 1);

    // DC bin is outside the scan range
    clear_mem();
    mem1[0] = {14'sd8000, 14'sd7000};
    minpwr = 28'd1;
    run_scan(0, edges);
    check_result("dc_skip", 514, 1, 0, 0);

    // start re-pulsed mid-scan is ignored; then restart from DONE
    clear_mem();
    mem1[37] = {14'sd100, -14'sd50};
    minpwr = 28'd1000;
    run_scan(100, edges);
    check_result("repulse", 514, 37, 12500, 1);
    run_scan(0, edges);
    check_result("restart", 514, 37, 12500, 1);

    // asynchronous reset mid-scan
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (50) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_addr", 32'(rdaddr1), 32'd0);
    check("arst_res", {found, detectdone, maxbin, maxpwr[19:0]}, 32'd0);
    @(negedge clk); @(negedge clk); reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_addr", 32'(rdaddr1), 32'd0);
    check("post_rst_dd", 32'(detectdone), 32'd0);
    run_scan(0, edges);
    check_result("post_rst", 514, 37, 12500, 1);

    // single-bin instance
    mem2[5] = {14'sd3, 14'sd4};
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    edges = 0;
    while (edges < 20) begin
      @(posedge clk); #1; edges++;
      if (detectdone2) break;
    end
    check("one_edge", 32'(edges), 32'd4);
    check("one_maxbin", 32'(maxbin2), 32'd5);
    check("one_maxpwr", 32'(maxpwr2), 32'd25);
    check("one_found", 32'(found2), 32'd1);
    check("one_addr", 32'(rdaddr12), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/peak_bin_detect.md
PEAK_BIN_DETECT -- requirements
Module: peak_bin_detect

Interface
REQ-001 SHALL provide parameter BIN_LO, default 1, meaning first FFT bin scanned (DC skipped).
REQ-002 SHALL provide parameter BIN_HI, default 511, meaning last FFT bin scanned (positive half of 1024-point FFT); BIN_LO <= BIN_HI <= 1023.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: FFT for mic 1 complete, sampled high on a clock edge.
REQ-006 SHALL have port minpwr, input, 28 bits: unsigned detection threshold on bin power.
REQ-007 SHALL have port ram1q, input, 28 bits: FFT RAM 1 read data, [27:14] signed real, [13:0] signed imaginary, 1-cycle registered read latency.
REQ-008 SHALL have port rdaddr1, output, 10 bits: FFT RAM 1 read address.
REQ-009 SHALL have port maxbin, output, 10 bits: bin index of peak power.
REQ-010 SHALL have port maxpwr, output, 28 bits: power at maxbin.
REQ-011 SHALL have port found, output, 1 bit: peak power >= minpwr.
REQ-012 SHALL have port detectdone, output, 1 bit: level, result valid.
REQ-013 SHALL have port busy, output, 1 bit: scan in progress.

Function
REQ-014 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-015 IDLE/DONE: start=1 at an edge SHALL enter SCAN, clear detectdone, found, running max and running bin, and set rdaddr1=BIN_LO.
REQ-016 SCAN SHALL increment rdaddr1 by 1 per cycle up to BIN_HI, then enter DRAIN; N = BIN_HI-BIN_LO+1 addresses issued on consecutive cycles.
REQ-017 Pipeline SHALL be: address cycle k, ram1q valid k+1, power registered k+2, max compare/update k+3; a valid tag SHALL travel with each bin index.
REQ-018 Power SHALL equal re*re + im*im using signed 14x14 products, unsigned 28-bit sum, no truncation (max 2^27 at re=im=-8192).
REQ-019 Compare SHALL use strict greater-than; ties keep the lower bin index.
REQ-020 DRAIN SHALL last until the last valid tag retires, then enter DONE.
REQ-021 On entering DONE: maxbin and maxpwr SHALL take the running values, found = (maxpwr >= minpwr), detectdone=1, busy=0.
REQ-022 detectdone SHALL rise on the (N+3)th rising edge after the edge that sampled start, and SHALL stay high until the next accepted start or reset.
REQ-023 In DONE, rdaddr1 SHALL equal maxbin, so the downstream beam stage reads mic-1 data at the peak bin.
REQ-024 If found=0, maxbin SHALL still report the scanned peak; downstream gating is by found.
REQ-025 busy SHALL be 1 in SCAN and DRAIN only.
REQ-026 start during SCAN or DRAIN SHALL be ignored, with no restart and no effect on results.
REQ-027 start in DONE SHALL restart per REQ-015; detectdone SHALL fall on that same edge.
REQ-028 If all bins scanned have power 0, result SHALL be maxbin=BIN_LO, maxpwr=0.

Reset
REQ-029 reset low SHALL, asynchronously and at any time (including mid-scan), force IDLE, rdaddr1=0, maxbin=0, maxpwr=0, found=0, detectdone=0, busy=0, and clear the pipeline valid tags.
REQ-030 After reset release, the block SHALL not act until a new start.

Verification
REQ-031 RAM all zero except bin 37 = {re=100, im=-50}, minpwr=1000, start pulse -> detectdone at edge N+3=514, maxbin=37, maxpwr=12500, found=1, rdaddr1=37.
REQ-032 Bins 20 and 300 both {re=-8192, im=-8192} -> maxbin=20, maxpwr=134217728 (no overflow), ties keep lower bin.
REQ-033 Bin 0 = large value, rest zero -> maxbin=1, maxpwr=0, found=0 when minpwr=1.
REQ-034 start re-pulsed at cycle 100 of a scan -> ignored, detectdone still at edge 514 with unchanged results; then start in DONE -> detectdone falls on that edge and rises 514 edges later.
REQ-035 reset asserted asynchronously mid-SCAN (between edges) -> all outputs zero immediately; after release no activity until start, then a correct full scan.
REQ-036 BIN_LO=BIN_HI=5 with bin 5={3,4} -> detectdone at edge 4, maxbin=5, maxpwr=25.
